// File: rtl/sensor_scanner.sv
// Scans NUM_SENSORS mux-selected sensor lines into a frame and hands it off over valid/ready.
// Optional macro SENSOR_SCANNER_CHANGE_ONLY_EN suppresses frames identical to the last one delivered.
module sensor_scanner #(
  parameter int NUM_SENSORS   = 4,
  parameter int SETTLE_CYCLES = 2,
  localparam int SEL_W        = $clog2(NUM_SENSORS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scan_en,
  input  logic                   sensor_in,
  input  logic                   frame_ready,
  output logic [SEL_W-1:0]       mux_sel,
  output logic [NUM_SENSORS-1:0] sensors,
  output logic                   frame_valid,
  output logic                   scan_busy
);

  // state   | meaning
  // IDLE    | waiting for scan_en
  // SETTLE  | select driven, waiting SETTLE_CYCLES for the mux output to settle
  // SAMPLE  | capture sensor_in into the shadow bit for the current channel
  // PRESENT | frame offered to the consumer until frame_ready
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_PRESENT} state_t;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SENSORS - 1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [SEL_W-1:0]       r_mux_sel;
  logic [NUM_SENSORS-1:0] r_shadow;
  logic [NUM_SENSORS-1:0] r_sensors;
  logic                   r_frame_valid;
  logic                   r_scan_busy;
  logic [NUM_SENSORS-1:0] w_frame;
  logic                   w_skip;

  // Shadow with this cycle's sample merged in, so the last channel lands in the frame directly.
  always_comb begin
    w_frame            = r_shadow;
    w_frame[r_mux_sel] = sensor_in;
  end

`ifdef SENSOR_SCANNER_CHANGE_ONLY_EN
  logic [NUM_SENSORS-1:0] r_last_delivered;
  logic                   r_delivered_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_delivered <= '0;
      r_delivered_any  <= 1'b0;
    end else if (r_state == S_PRESENT && frame_ready) begin
      r_last_delivered <= r_sensors;
      r_delivered_any  <= 1'b1;
    end
  end

  assign w_skip = r_delivered_any && (w_frame == r_last_delivered);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_mux_sel     <= '0;
      r_shadow      <= '0;
      r_sensors     <= '0;
      r_frame_valid <= 1'b0;
      r_scan_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (scan_en) begin
            r_state     <= S_SETTLE;
            r_mux_sel   <= '0;
            r_cnt       <= '0;
            r_scan_busy <= 1'b1;
          end
        end
        S_SETTLE, S_SAMPLE: begin
          if (!scan_en) begin
            // Abort drops the partial frame; sensors keeps the last delivered value.
            r_state     <= S_IDLE;
            r_mux_sel   <= '0;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_scan_busy <= 1'b0;
          end else if (r_state == S_SETTLE) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_CNT) r_state <= S_SAMPLE;
          end else begin
            r_shadow <= w_frame;
            r_cnt    <= '0;
            if (r_mux_sel != LAST_SEL) begin
              r_mux_sel <= r_mux_sel + SEL_W'(1);
              r_state   <= S_SETTLE;
            end else if (w_skip) begin
              r_mux_sel <= '0;
              r_state   <= S_SETTLE;
            end else begin
              r_sensors     <= w_frame;
              r_frame_valid <= 1'b1;
              r_scan_busy   <= 1'b0;
              r_state       <= S_PRESENT;
            end
          end
        end
        S_PRESENT: begin
          if (frame_ready) begin
            r_frame_valid <= 1'b0;
            r_mux_sel     <= '0;
            r_cnt         <= '0;
            r_scan_busy   <= scan_en;
            r_state       <= scan_en ? S_SETTLE : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mux_sel     = r_mux_sel;
  assign sensors     = r_sensors;
  assign frame_valid = r_frame_valid;
  assign scan_busy   = r_scan_busy;

endmodule

// File: tb/tb_sensor_scanner.sv
// Directed self-checking bench for sensor_scanner (default parameters, 13-cycle frame).
module tb_sensor_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_en;
  logic       sensor_in;
  logic       frame_ready;
  logic [1:0] mux_sel;
  logic [3:0] sensors;
  logic       frame_valid;
  logic       scan_busy;
  logic [3:0] pattern;

  int checks = 0;
  int errors = 0;

  sensor_scanner dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .sensor_in(sensor_in),
    .frame_ready(frame_ready), .mux_sel(mux_sel), .sensors(sensors),
    .frame_valid(frame_valid), .scan_busy(scan_busy)
  );

  always #5 clk = ~clk;

  // Board mux model: return line reflects the selected sensor.
  assign sensor_in = pattern[mux_sel];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; scan_en = 1'b0; frame_ready = 1'b0; pattern = 4'b0000;
    step(); step();
    rst = 1'b0;
    checks++; if (mux_sel !== 2'd0) begin errors++; $display("FAIL reset_mux_sel got %0d exp 0", mux_sel); end
    checks++; if (sensors !== 4'b0000) begin errors++; $display("FAIL reset_sensors got %b exp 0000", sensors); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", frame_valid); end
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", scan_busy); end
    step();
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", scan_busy); end
  endtask

  task automatic test_first_frame();
    pattern = 4'b0110; frame_ready = 1'b1; scan_en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k <= 12) begin
        checks++; if (mux_sel !== 2'((k - 1) / 3)) begin errors++; $display("FAIL first_mux_sel cycle %0d got %0d exp %0d", k, mux_sel, (k - 1) / 3); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL first_valid_early cycle %0d got %b exp 0", k, frame_valid); end
        checks++; if (scan_busy !== 1'b1) begin errors++; $display("FAIL first_busy cycle %0d got %b exp 1", k, scan_busy); end
      end else begin
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL first_valid_13 got %b exp 1", frame_valid); end
        checks++; if (sensors !== 4'b0110) begin errors++; $display("FAIL first_sensors got %b exp 0110", sensors); end
        checks++; if (mux_sel !== 2'd3) begin errors++; $display("FAIL first_present_sel got %0d exp 3", mux_sel); end
        checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL first_present_busy got %b exp 0", scan_busy); end
      end
    end
    scan_en = 1'b0;
    step();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL first_after_xfer_valid got %b exp 0", frame_valid); end
    checks++; if (sensors !== 4'b0110) begin errors++; $display("FAIL first_after_xfer_sensors got %b exp 0110", sensors); end
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL first_after_xfer_busy got %b exp 0", scan_busy); end
    step();
  endtask

  task automatic test_hold();
    pattern = 4'b1010; frame_ready = 1'b0; scan_en = 1'b1;
    for (int k = 1; k <= 13; k++) step();
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL hold_valid_13 got %b exp 1", frame_valid); end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL hold_valid wait %0d got %b exp 1", k, frame_valid); end
      checks++; if (sensors !== 4'b1010) begin errors++; $display("FAIL hold_sensors wait %0d got %b exp 1010", k, sensors); end
      checks++; if (mux_sel !== 2'd3) begin errors++; $display("FAIL hold_mux_sel wait %0d got %0d exp 3", k, mux_sel); end
    end
    frame_ready = 1'b1;
    step();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got %b exp 0", frame_valid); end
    checks++; if (mux_sel !== 2'd0) begin errors++; $display("FAIL hold_release_sel got %0d exp 0", mux_sel); end
    checks++; if (scan_busy !== 1'b1) begin errors++; $display("FAIL hold_release_busy got %b exp 1", scan_busy); end
    scan_en = 1'b0;
    step();
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL hold_stop_busy got %b exp 0", scan_busy); end
  endtask

  task automatic test_abort();
    pattern = 4'b1111; frame_ready = 1'b1; scan_en = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    checks++; if (mux_sel !== 2'd2) begin errors++; $display("FAIL abort_pre_sel got %0d exp 2", mux_sel); end
    scan_en = 1'b0;
    step();
    checks++; if (mux_sel !== 2'd0) begin errors++; $display("FAIL abort_sel got %0d exp 0", mux_sel); end
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", scan_busy); end
    for (int k = 0; k < 14; k++) begin
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL abort_no_frame cycle %0d got %b exp 0", k, frame_valid); end
      checks++; if (sensors !== 4'b1010) begin errors++; $display("FAIL abort_sensors cycle %0d got %b exp 1010", k, sensors); end
      step();
    end
  endtask

  task automatic test_reset_mid_handshake();
    pattern = 4'b0011; frame_ready = 1'b0; scan_en = 1'b1;
    for (int k = 1; k <= 13; k++) step();
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid got %b exp 1", frame_valid); end
    checks++; if (sensors !== 4'b0011) begin errors++; $display("FAIL rstmid_sensors got %b exp 0011", sensors); end
    rst = 1'b1;
    step();
    rst = 1'b0; scan_en = 1'b0;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid_after got %b exp 0", frame_valid); end
    checks++; if (sensors !== 4'b0000) begin errors++; $display("FAIL rstmid_sensors_after got %b exp 0000", sensors); end
    checks++; if (mux_sel !== 2'd0) begin errors++; $display("FAIL rstmid_sel_after got %0d exp 0", mux_sel); end
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after got %b exp 0", scan_busy); end
    step();
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    pattern = 4'b1111; frame_ready = 1'b1; scan_en = 1'b1;
    for (int k = 1; k <= 39; k++) begin
      step();
`ifdef SENSOR_SCANNER_CHANGE_ONLY_EN
      exp_v = (k == 13);
`else
      exp_v = (k % 13 == 0);
`endif
      checks++; if (frame_valid !== exp_v) begin errors++; $display("FAIL b2b_valid cycle %0d got %b exp %b", k, frame_valid, exp_v); end
      if (exp_v) begin
        checks++; if (sensors !== 4'b1111) begin errors++; $display("FAIL b2b_sensors cycle %0d got %b exp 1111", k, sensors); end
      end
    end
    scan_en = 1'b0;
    step();
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL b2b_stop_busy got %b exp 0", scan_busy); end
    checks++; if (mux_sel !== 2'd0) begin errors++; $display("FAIL b2b_stop_sel got %0d exp 0", mux_sel); end
  endtask

  task automatic test_change_only();
    logic exp_v;
    int   exp_k;
    rst = 1'b1; step(); rst = 1'b0;
    pattern = 4'b0101; frame_ready = 1'b1; scan_en = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step();
`ifdef SENSOR_SCANNER_CHANGE_ONLY_EN
      exp_v = (k == 13);
`else
      exp_v = (k == 13) || (k == 26);
`endif
      checks++; if (frame_valid !== exp_v) begin errors++; $display("FAIL chg_valid cycle %0d got %b exp %b", k, frame_valid, exp_v); end
      if (exp_v) begin
        checks++; if (sensors !== 4'b0101) begin errors++; $display("FAIL chg_sensors cycle %0d got %b exp 0101", k, sensors); end
      end
    end
    pattern = 4'b1101;
`ifdef SENSOR_SCANNER_CHANGE_ONLY_EN
    exp_k = 38;
`else
    exp_k = 39;
`endif
    for (int k = 27; k <= 40; k++) begin
      step();
      exp_v = (k == exp_k);
      checks++; if (frame_valid !== exp_v) begin errors++; $display("FAIL chg_new_valid cycle %0d got %b exp %b", k, frame_valid, exp_v); end
      if (exp_v) begin
        checks++; if (sensors !== 4'b1101) begin errors++; $display("FAIL chg_new_sensors cycle %0d got %b exp 1101", k, sensors); end
      end
    end
    scan_en = 1'b0;
    step(); step();
  endtask

  initial begin
    rst = 1'b1; scan_en = 1'b0; frame_ready = 1'b0; pattern = 4'b0000;
    #1;
    test_reset();
    test_first_frame();
    test_hold();
    test_abort();
    test_reset_mid_handshake();
    test_back_to_back();
    test_change_only();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
